// File: rtl/lfsr_rnd_pkg.sv
// Shared definitions for the 32-bit random-stream LFSR: word width, the
// generator's reset seed, feedback tap positions, checker state encoding and
// a popcount helper used by the optional bit-error accumulator.
package lfsr_rnd_pkg;

    localparam int          LFSR_W    = 32;
    localparam logic [31:0] LFSR_SEED = 32'hbed4dead;
    localparam int          TAP_HI    = 31;
    localparam int          TAP_LO    = 1;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SYNC   = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    function automatic logic [5:0] popcount32(input logic [LFSR_W-1:0] v);
        logic [5:0] cnt;
        cnt = '0;
        for (int i = 0; i < LFSR_W; i++) begin
            cnt = cnt + 6'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lfsr_rnd_chk_adv.sv
// Combinational LFSR word advance: applies BITS single steps
// x = {x[31]^x[1], x[31:1]} to the input word.
// Ports:
//   x_in  - current 32-bit LFSR word
//   x_out - word after BITS steps
module lfsr_adv
    import lfsr_rnd_pkg::*;
#(
    parameter int BITS = 31
) (
    input  logic [LFSR_W-1:0] x_in,
    output logic [LFSR_W-1:0] x_out
);

    logic [LFSR_W-1:0] x;

    always_comb begin
        x = x_in;
        for (int i = 0; i < BITS; i++) begin
            x = {x[TAP_HI] ^ x[TAP_LO], x[LFSR_W-1:1]};
        end
        x_out = x;
    end

endmodule

// File: rtl/lfsr_rnd_chk.sv
// Receive-side checker for the 32-bit LFSR random stream. Seeds itself from
// the incoming words, predicts each next word, locks after LOCK_CNT
// consecutive matches and drops lock after LOSS_CNT consecutive misses.
// Mismatches while locked are counted in a saturating counter.
//
// Optional build macro: LFSR_RND_CHK_BITERR_EN adds O_bit_err_cnt, the
// saturating sum of mismatched bits over all locked-state mismatches.
//
// Ports:
//   I_clk         - clock
//   I_reset       - asynchronous active-high reset
//   I_valid       - I_data carries a stream word this cycle
//   I_data        - received random word
//   I_clear       - synchronous clear of the error counter(s)
//   O_locked      - checker is in LOCKED
//   O_err         - one-cycle pulse: previous valid word mismatched while LOCKED
//   O_bit_err_cnt - (macro only) saturating mismatched-bit count
//   O_err_cnt     - saturating mismatched-word count
//
// state  | meaning
// HUNT   | waiting for a non-zero word to seed the prediction
// SYNC   | predicting from the seed, counting consecutive matches
// LOCKED | prediction trusted; mismatches are counted as errors
module lfsr_rnd_chk
    import lfsr_rnd_pkg::*;
#(
    parameter int BITS     = 31,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic              I_clk,
    input  logic              I_reset,
    input  logic              I_valid,
    input  logic [LFSR_W-1:0] I_data,
    input  logic              I_clear,
    output logic              O_locked,
    output logic              O_err,
`ifdef LFSR_RND_CHK_BITERR_EN
    output logic [ERR_W-1:0]  O_bit_err_cnt,
`endif
    output logic [ERR_W-1:0]  O_err_cnt
);

    localparam logic [7:0]       LOCK_C  = 8'(LOCK_CNT);
    localparam logic [7:0]       LOSS_C  = 8'(LOSS_CNT);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic [LFSR_W-1:0] expected_q, expected_d;
    logic [7:0]        match_cnt_q, match_cnt_d;
    logic [7:0]        miss_cnt_q, miss_cnt_d;
    logic              err_q, err_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic [LFSR_W-1:0] adv_data;
    logic [LFSR_W-1:0] adv_exp;
    logic              data_match;
    logic              data_zero;
    logic              count_err;

    // Seed path and prediction path use separate advance instances.
    lfsr_adv #(.BITS(BITS)) u_adv_seed (.x_in(I_data),     .x_out(adv_data));
    lfsr_adv #(.BITS(BITS)) u_adv_pred (.x_in(expected_q), .x_out(adv_exp));

    assign data_match = (I_data == expected_q);
    assign data_zero  = (I_data == '0);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        err_d       = 1'b0;
        count_err   = 1'b0;
        if (I_valid) begin
            case (state_q)
                HUNT: begin
                    // Zero is the degenerate LFSR state and cannot seed.
                    if (!data_zero) begin
                        expected_d  = adv_data;
                        match_cnt_d = '0;
                        state_d     = SYNC;
                    end
                end
                SYNC: begin
                    if (data_match) begin
                        match_cnt_d = match_cnt_q + 8'd1;
                        expected_d  = adv_exp;
                        if (match_cnt_q + 8'd1 == LOCK_C) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else if (!data_zero) begin
                        expected_d  = adv_data;
                        match_cnt_d = '0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Never reseed here, so a single corrupt word cannot
                    // derail the prediction.
                    expected_d = adv_exp;
                    if (data_match) begin
                        miss_cnt_d = '0;
                    end else begin
                        err_d      = 1'b1;
                        count_err  = 1'b1;
                        miss_cnt_d = miss_cnt_q + 8'd1;
                        if (miss_cnt_q + 8'd1 == LOSS_C) begin
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // Clear takes priority over a coincident error.
        err_cnt_d = err_cnt_q;
        if (I_clear) begin
            err_cnt_d = '0;
        end else if (count_err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state_q     <= HUNT;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign O_locked  = (state_q == LOCKED);
    assign O_err     = err_q;
    assign O_err_cnt = err_cnt_q;

`ifdef LFSR_RND_CHK_BITERR_EN
    // Sum is widened so a 32-bit popcount can never wrap before saturation.
    localparam int BSW = ERR_W + 6;

    logic [ERR_W-1:0] bit_err_cnt_q, bit_err_cnt_d;
    logic [BSW-1:0]   bit_sum;

    always_comb begin
        bit_sum       = BSW'(bit_err_cnt_q) + BSW'(popcount32(I_data ^ expected_q));
        bit_err_cnt_d = bit_err_cnt_q;
        if (I_clear) begin
            bit_err_cnt_d = '0;
        end else if (count_err) begin
            bit_err_cnt_d = (|bit_sum[BSW-1:ERR_W]) ? ERR_MAX : bit_sum[ERR_W-1:0];
        end
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            bit_err_cnt_q <= '0;
        end else begin
            bit_err_cnt_q <= bit_err_cnt_d;
        end
    end

    assign O_bit_err_cnt = bit_err_cnt_q;
`endif

endmodule
